// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, DMA), the arbiter and memory.
// slave  : the arbiter's view
// master : the view of the requesters and the memory model
interface mem_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_rw;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_rw;
   logic              dma_ack;
   logic [DATA_W-1:0] dma_rdata;

   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rw;
   logic [DATA_W-1:0] mem_rdata;

   logic [1:0]        owner;

   modport slave (
      input  cpu_req, cpu_addr, cpu_wdata, cpu_rw,
      output cpu_ack, cpu_rdata,
      input  dma_req, dma_addr, dma_wdata, dma_rw,
      output dma_ack, dma_rdata,
      output mem_en, mem_addr, mem_wdata, mem_rw,
      input  mem_rdata,
      output owner
   );

   modport master (
      output cpu_req, cpu_addr, cpu_wdata, cpu_rw,
      input  cpu_ack, cpu_rdata,
      output dma_req, dma_addr, dma_wdata, dma_rw,
      input  dma_ack, dma_rdata,
      input  mem_en, mem_addr, mem_wdata, mem_rw,
      output mem_rdata,
      input  owner
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter. CPU normally wins; DMA gets bursts of up to
// MAX_BURST transfers and overrides CPU once it has waited STARVE_LIMIT cycles.
// Each transfer is ACC (strobe to memory) followed by ACK (return data/ack).
module mem_arbiter #(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 8,
   parameter int MAX_BURST    = 4,
   parameter int STARVE_LIMIT = 8
) (
   input logic          CLK,
   input logic          RSTn,
   mem_arbiter_if.slave bus
);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {IDLE, C_ACC, C_ACK, D_ACC, D_ACK} state_t;

   state_t          state, nxt, arb_nxt;
   logic [BW-1:0]   burst_cnt;
   logic [SW-1:0]   starve_cnt;
   logic            starve_full;
   logic            in_dma;
   logic            burst_open;

   assign starve_full = (starve_cnt == SW'(STARVE_LIMIT));
   assign in_dma      = (state == D_ACC) || (state == D_ACK);
   assign burst_open  = (burst_cnt < BW'(MAX_BURST));

   // State register
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= IDLE;
      else       state <= nxt;
   end

   // Arbitration decision and next-state selection
   always_comb begin
      arb_nxt = IDLE;
      if (bus.dma_req && starve_full) arb_nxt = D_ACC;
      else if (bus.cpu_req)           arb_nxt = C_ACC;
      else if (bus.dma_req)           arb_nxt = D_ACC;

      nxt = IDLE;
      case (state)
         IDLE, C_ACK: nxt = arb_nxt;
         C_ACC:       nxt = C_ACK;
         D_ACC:       nxt = D_ACK;
         D_ACK:       nxt = (bus.dma_req && burst_open) ? D_ACC : arb_nxt;
         default:     nxt = IDLE;
      endcase
   end

   // Burst length tracking; a DMA regrant via normal arbitration after a full
   // burst counts as a fresh grant, so the counter restarts instead of wrapping
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)
         burst_cnt <= '0;
      else if (nxt == D_ACC)
         burst_cnt <= (state == D_ACK && burst_open) ? burst_cnt + BW'(1) : BW'(1);
      else if (nxt != D_ACK)
         burst_cnt <= '0;
   end

   // DMA wait counter, saturating, cleared whenever DMA is granted
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)
         starve_cnt <= '0;
      else if (nxt == D_ACC)
         starve_cnt <= '0;
      else if (bus.dma_req && !in_dma && !starve_full)
         starve_cnt <= starve_cnt + SW'(1);
   end

   // Output decode from state; idle bus is all zero with mem_rw parked at read
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_rw    = 1'b1;
      bus.cpu_ack   = 1'b0;
      bus.cpu_rdata = '0;
      bus.dma_ack   = 1'b0;
      bus.dma_rdata = '0;
      bus.owner     = 2'd0;
      case (state)
         C_ACC: begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_rw    = bus.cpu_rw;
            bus.owner     = 2'd1;
         end
         C_ACK: begin
            bus.cpu_ack   = 1'b1;
            bus.cpu_rdata = bus.mem_rdata;
            bus.owner     = 2'd1;
         end
         D_ACC: begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
            bus.mem_rw    = bus.dma_rw;
            bus.owner     = 2'd2;
         end
         D_ACK: begin
            bus.dma_ack   = 1'b1;
            bus.dma_rdata = bus.mem_rdata;
            bus.owner     = 2'd2;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, CPU read, tie, DMA burst,
// starvation override and reset abort.
module tb_mem_arbiter;
   logic CLK;
   logic RSTn;
   int   total;
   int   bad;
   int   cpu_done, dma_done, cpu_target, dma_target;
   logic [1:0] olog [0:31];
   logic [7:0] wr_addr, wr_data;

   mem_arbiter_if #(.DATA_W(8), .ADDR_W(8)) bus ();

   mem_arbiter #(.DATA_W(8), .ADDR_W(8), .MAX_BURST(4), .STARVE_LIMIT(8)) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory model: read data is addr ^ 0xB5, one cycle after the strobe;
   // the last write is latched for inspection.
   always @(posedge CLK) begin
      if (bus.mem_en) begin
         if (bus.mem_rw) bus.mem_rdata <= bus.mem_addr ^ 8'hB5;
         else begin
            wr_addr <= bus.mem_addr;
            wr_data <= bus.mem_wdata;
         end
      end
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      RSTn = 1'b0;
      bus.cpu_req = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_rw = 1;
      bus.dma_req = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_rw = 1;
      cpu_done = 0; dma_done = 0;
      tick; tick;
      RSTn = 1'b1;
   endtask

   // Each requester drops its req in the cycle its final ack is seen.
   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         tick;
         olog[i] = bus.owner;
         if (bus.cpu_ack) begin
            cpu_done++;
            if (cpu_done >= cpu_target) bus.cpu_req = 0;
         end
         if (bus.dma_ack) begin
            dma_done++;
            if (dma_done >= dma_target) bus.dma_req = 0;
         end
      end
   endtask

   task automatic test_reset;
      RSTn = 1'b0;
      bus.cpu_req = 1; bus.cpu_addr = 8'h11; bus.cpu_wdata = 8'h22; bus.cpu_rw = 0;
      bus.dma_req = 1; bus.dma_addr = 8'h33; bus.dma_wdata = 8'h44; bus.dma_rw = 0;
      #1;
      for (int k = 0; k < 2; k++) begin
         total++; if (bus.mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got %b want 0", bus.mem_en); end
         total++; if (bus.mem_rw !== 1'b1) begin bad++; $display("FAIL rst_mem_rw got %b want 1", bus.mem_rw); end
         total++; if (bus.owner !== 2'd0) begin bad++; $display("FAIL rst_owner got %0d want 0", bus.owner); end
         total++; if (bus.cpu_ack !== 1'b0 || bus.dma_ack !== 1'b0) begin
            bad++; $display("FAIL rst_acks got %b%b want 00", bus.cpu_ack, bus.dma_ack); end
         total++; if (bus.mem_addr !== 8'h00) begin bad++; $display("FAIL rst_mem_addr got %h want 00", bus.mem_addr); end
         tick; tick;
      end
   endtask

   task automatic test_cpu_read;
      do_reset;
      bus.cpu_req = 1; bus.cpu_addr = 8'h10; bus.cpu_rw = 1;
      tick;
      total++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 8'h10 || bus.mem_rw !== 1'b1) begin
         bad++; $display("FAIL rd_acc got en=%b addr=%h rw=%b want 1 10 1", bus.mem_en, bus.mem_addr, bus.mem_rw); end
      total++; if (bus.owner !== 2'd1 || bus.cpu_ack !== 1'b0) begin
         bad++; $display("FAIL rd_acc_owner got owner=%0d ack=%b want 1 0", bus.owner, bus.cpu_ack); end
      tick;
      total++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'hA5) begin
         bad++; $display("FAIL rd_ack got ack=%b data=%h want 1 a5", bus.cpu_ack, bus.cpu_rdata); end
      total++; if (bus.mem_en !== 1'b0 || bus.owner !== 2'd1) begin
         bad++; $display("FAIL rd_ack_bus got en=%b owner=%0d want 0 1", bus.mem_en, bus.owner); end
      bus.cpu_req = 0;
      tick;
      total++; if (bus.mem_en !== 1'b0 || bus.owner !== 2'd0 || bus.cpu_ack !== 1'b0 ||
                   bus.cpu_rdata !== 8'h00 || bus.mem_rw !== 1'b1 || bus.mem_addr !== 8'h00) begin
         bad++; $display("FAIL rd_idle got en=%b owner=%0d ack=%b rdata=%h rw=%b addr=%h want 0 0 0 00 1 00",
                         bus.mem_en, bus.owner, bus.cpu_ack, bus.cpu_rdata, bus.mem_rw, bus.mem_addr); end
   endtask

   task automatic test_tie;
      do_reset;
      bus.cpu_req = 1; bus.cpu_addr = 8'h10; bus.cpu_rw = 1;
      bus.dma_req = 1; bus.dma_addr = 8'h20; bus.dma_wdata = 8'h3C; bus.dma_rw = 0;
      tick;
      total++; if (bus.owner !== 2'd1 || bus.mem_addr !== 8'h10) begin
         bad++; $display("FAIL tie_first got owner=%0d addr=%h want 1 10", bus.owner, bus.mem_addr); end
      tick;
      total++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'hA5 || bus.dma_ack !== 1'b0) begin
         bad++; $display("FAIL tie_cpu_ack got ack=%b data=%h dack=%b want 1 a5 0", bus.cpu_ack, bus.cpu_rdata, bus.dma_ack); end
      bus.cpu_req = 0;
      tick;
      total++; if (bus.owner !== 2'd2 || bus.mem_en !== 1'b1 || bus.mem_rw !== 1'b0 ||
                   bus.mem_wdata !== 8'h3C || bus.mem_addr !== 8'h20) begin
         bad++; $display("FAIL tie_dma_acc got owner=%0d en=%b rw=%b wdata=%h addr=%h want 2 1 0 3c 20",
                         bus.owner, bus.mem_en, bus.mem_rw, bus.mem_wdata, bus.mem_addr); end
      tick;
      total++; if (bus.dma_ack !== 1'b1 || bus.cpu_ack !== 1'b0) begin
         bad++; $display("FAIL tie_dma_ack got dack=%b cack=%b want 1 0", bus.dma_ack, bus.cpu_ack); end
      bus.dma_req = 0;
      tick;
      total++; if (bus.owner !== 2'd0 || wr_addr !== 8'h20 || wr_data !== 8'h3C) begin
         bad++; $display("FAIL tie_end got owner=%0d waddr=%h wdata=%h want 0 20 3c", bus.owner, wr_addr, wr_data); end
   endtask

   task automatic test_burst;
      logic [1:0] exp_o [0:13];
      exp_o = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1,
                2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
      do_reset;
      cpu_target = 1; dma_target = 6;
      bus.dma_req = 1; bus.dma_addr = 8'h30; bus.dma_wdata = 8'h55; bus.dma_rw = 0;
      tick;
      total++; if (bus.owner !== 2'd2) begin bad++; $display("FAIL burst_start got owner=%0d want 2", bus.owner); end
      bus.cpu_req = 1; bus.cpu_addr = 8'h40; bus.cpu_rw = 1;
      run_cycles(14);
      for (int i = 0; i < 14; i++) begin
         total++; if (olog[i] !== exp_o[i]) begin
            bad++; $display("FAIL burst_owner[c%0d] got %0d want %0d", i + 2, olog[i], exp_o[i]); end
      end
      total++; if (cpu_done != 1 || dma_done != 6) begin
         bad++; $display("FAIL burst_counts got cpu=%0d dma=%0d want 1 6", cpu_done, dma_done); end
   endtask

   task automatic test_starve;
      logic [1:0] exp_o [0:12];
      int first_dma;
      exp_o = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
      do_reset;
      cpu_target = 5; dma_target = 1;
      bus.cpu_req = 1; bus.cpu_addr = 8'h01; bus.cpu_rw = 1;
      bus.dma_req = 1; bus.dma_addr = 8'h02; bus.dma_rw = 1;
      run_cycles(13);
      first_dma = 99;
      for (int i = 12; i >= 0; i--) if (olog[i] == 2'd2) first_dma = i + 1;
      for (int i = 0; i < 13; i++) begin
         total++; if (olog[i] !== exp_o[i]) begin
            bad++; $display("FAIL starve_owner[c%0d] got %0d want %0d", i + 1, olog[i], exp_o[i]); end
      end
      total++; if (first_dma > 10) begin
         bad++; $display("FAIL starve_wait got %0d cycles want <= 10", first_dma); end
   endtask

   task automatic test_abort;
      logic [1:0] exp_o [0:4];
      exp_o = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
      do_reset;
      bus.dma_req = 1; bus.dma_addr = 8'h50; bus.dma_wdata = 8'h77; bus.dma_rw = 0;
      tick;
      total++; if (bus.owner !== 2'd2 || bus.mem_en !== 1'b1) begin
         bad++; $display("FAIL abort_acc got owner=%0d en=%b want 2 1", bus.owner, bus.mem_en); end
      #1 RSTn = 1'b0;
      #1;
      total++; if (bus.owner !== 2'd0 || bus.mem_en !== 1'b0 || bus.dma_ack !== 1'b0) begin
         bad++; $display("FAIL abort_async got owner=%0d en=%b dack=%b want 0 0 0", bus.owner, bus.mem_en, bus.dma_ack); end
      tick;
      total++; if (bus.owner !== 2'd0 || bus.dma_ack !== 1'b0) begin
         bad++; $display("FAIL abort_held got owner=%0d dack=%b want 0 0", bus.owner, bus.dma_ack); end
      cpu_done = 0; dma_done = 0; cpu_target = 1; dma_target = 1;
      bus.cpu_req = 1; bus.cpu_addr = 8'h60; bus.cpu_rw = 1;
      RSTn = 1'b1;
      run_cycles(5);
      for (int i = 0; i < 5; i++) begin
         total++; if (olog[i] !== exp_o[i]) begin
            bad++; $display("FAIL abort_owner[c%0d] got %0d want %0d", i + 1, olog[i], exp_o[i]); end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      cpu_target = 1; dma_target = 1;
      test_reset;
      test_cpu_read;
      test_tie;
      test_burst;
      test_starve;
      test_abort;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
